shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequenced shift-register controller.
//
// A start request in IDLE latches seed, step count and shift mode. The block
// then applies one shift per unpaused cycle until the step count is used up,
// pulses done for one cycle and returns to IDLE. Abort drops back to IDLE at
// once and leaves count and steps_left holding their current values.
//
// Configuration macro:
//   SHIFT_SEQ_JOHNSON_EN  defined   -> mode 2'b10 performs a Johnson shift
//                         undefined -> mode 2'b10 behaves as ring-left
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       begin a sequence (sampled in IDLE only)
//   mode        00 ring-left, 01 ring-right, 10 Johnson, 11 hold (latched at start)
//   seed        initial pattern (latched at start)
//   steps       number of shifts to perform (latched at start)
//   pause       freeze shifting and step decrement while in RUN
//   abort       return to IDLE from RUN or DONE; blocks start in IDLE
//   count       current shift-register pattern
//   steps_left  remaining shifts
//   busy        high while in RUN
//   done        one-cycle pulse while in DONE
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] steps_left,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] steps_q;
  logic             busy_q;
  logic             done_q;

  // One shift of the pattern for the latched mode.
  function automatic logic [WIDTH-1:0] shift_once(input logic [1:0]       m,
                                                  input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = {c[WIDTH-2:0], c[WIDTH-1]};
      2'b01:   r = {c[0], c[WIDTH-1:1]};
`ifdef SHIFT_SEQ_JOHNSON_EN
      2'b10:   r = {c[WIDTH-2:0], ~c[WIDTH-1]};
`else
      2'b10:   r = {c[WIDTH-2:0], c[WIDTH-1]};
`endif
      default: r = c;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      count_q <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Abort in IDLE only has the effect of blocking start.
          if (start && !abort) begin
            count_q <= seed;
            steps_q <= steps;
            mode_q  <= mode;
            if (steps != '0) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              // Zero-length sequence goes straight to DONE.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end

        StRun: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!pause) begin
            count_q <= shift_once(mode_q, count_q);
            // steps_q is never zero in RUN, so this cannot underflow.
            steps_q <= steps_q - 1'b1;
            if (steps_q == WIDTH'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        StDone: begin
          // With or without abort, DONE lasts exactly one cycle.
          state_q <= StIdle;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign steps_left = steps_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] seed = '0;
  logic [W-1:0] steps = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] steps_left;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .steps      (steps),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is either running, just finished, or absent.
  logic         m_running;
  logic         m_fin;
  logic [1:0]   m_mode;
  logic [W-1:0] m_pat;
  logic [W-1:0] m_left;

  function automatic logic [W-1:0] rot(input logic [1:0] m, input logic [W-1:0] p);
    case (m)
      2'd0: return (p << 1) | (p >> (W - 1));
      2'd1: return (p >> 1) | (p << (W - 1));
`ifdef SHIFT_SEQ_JOHNSON_EN
      2'd2: return (p << 1) | W'(~p[W-1]);
`else
      2'd2: return (p << 1) | (p >> (W - 1));
`endif
      default: return p;
    endcase
  endfunction

  task automatic model_reset();
    m_running = 1'b0;
    m_fin     = 1'b0;
    m_mode    = 2'd0;
    m_pat     = '0;
    m_left    = '0;
  endtask

  task automatic model_step();
    if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_running) begin
      if (abort) begin
        m_running = 1'b0;
      end else if (!pause) begin
        m_pat  = rot(m_mode, m_pat);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_running = 1'b0;
          m_fin     = 1'b1;
        end
      end
    end else if (start && !abort) begin
      m_pat  = seed;
      m_left = steps;
      m_mode = mode;
      if (steps == 0) m_fin = 1'b1;
      else            m_running = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] ec, input logic [W-1:0] el,
                       input logic eb, input logic ed);
    n_cmp++;
    if (count !== ec || steps_left !== el || busy !== eb || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got count=%h steps_left=%0d busy=%b done=%b, want count=%h steps_left=%0d busy=%b done=%b",
               name, count, steps_left, busy, done, ec, el, eb, ed);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic [W-1:0] sd,
                       input logic [W-1:0] st, input logic p, input logic a);
    start = s; mode = m; seed = sd; steps = st; pause = p; abort = a;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic         s;
    logic [1:0]   m;
    logic [W-1:0] sd;
    logic [W-1:0] st;
    logic         p;
    logic         a;
    logic [W-1:0] ec;
    logic [W-1:0] el;
    logic         eb;
    logic         ed;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // start, mode, seed, steps, pause, abort -> count, steps_left, busy, done
    // Ring-left 3 steps from 00000001.
    tbl[0]  = '{1'b1, 2'd0, 8'h01, 8'd3, 1'b0, 1'b0, 8'h01, 8'd3, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h02, 8'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h04, 8'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h08, 8'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h08, 8'd0, 1'b0, 1'b0};
    // Zero-length sequence.
    tbl[5]  = '{1'b1, 2'd0, 8'hA5, 8'd0, 1'b0, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b0};
    // Ring-right 2 steps with a 2-cycle pause after the first shift.
    tbl[7]  = '{1'b1, 2'd1, 8'h80, 8'd2, 1'b0, 1'b0, 8'h80, 8'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h40, 8'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h40, 8'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h40, 8'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h20, 8'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h20, 8'd0, 1'b0, 1'b0};
    // Hold mode; start held high in RUN and DONE is ignored, not queued.
    tbl[13] = '{1'b1, 2'd3, 8'h3C, 8'd2, 1'b0, 1'b0, 8'h3C, 8'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 8'hFF, 8'd9, 1'b0, 1'b0, 8'h3C, 8'd1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 8'hFF, 8'd9, 1'b0, 1'b0, 8'h3C, 8'd0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 2'd0, 8'hFF, 8'd9, 1'b0, 1'b0, 8'h3C, 8'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h3C, 8'd0, 1'b0, 1'b0};
    // Abort in IDLE blocks start; abort in DONE still just returns to IDLE.
    tbl[18] = '{1'b1, 2'd0, 8'h55, 8'd4, 1'b0, 1'b1, 8'h3C, 8'd0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 2'd0, 8'h11, 8'd0, 1'b0, 1'b0, 8'h11, 8'd0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 2'd0, 8'h00, 8'd0, 1'b0, 1'b1, 8'h11, 8'd0, 1'b0, 1'b0};

    model_reset();

    // Reset state, checked while reset is still low after an edge.
    #7;
    check("reset_state", 8'h00, 8'd0, 1'b0, 1'b0);
    #5 reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].s, tbl[i].m, tbl[i].sd, tbl[i].st, tbl[i].p, tbl[i].a);
      tick();
      check($sformatf("vec%0d", i), tbl[i].ec, tbl[i].el, tbl[i].eb, tbl[i].ed);
    end
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();

    // Mode 10 from seed 0, 8 steps: Johnson fill, or stuck at 0 as ring-left.
    drive(1'b1, 2'd2, 8'h00, 8'd8, 1'b0, 1'b0);
    tick();
    check("johnson_accept", 8'h00, 8'd8, 1'b1, 1'b0);
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      logic [W-1:0] exp_c;
      tick();
`ifdef SHIFT_SEQ_JOHNSON_EN
      exp_c = W'((1 << k) - 1);
`else
      exp_c = '0;
`endif
      check($sformatf("johnson_step%0d", k), exp_c, W'(8 - k), k != 8, k == 8);
    end
    tick();

    // Abort mid-RUN at steps_left=5, then a fresh start is accepted.
    drive(1'b1, 2'd0, 8'h01, 8'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("abort_pre", 8'h04, 8'd5, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    check("abort_idle", 8'h04, 8'd5, 1'b0, 1'b0);
    abort = 1'b0;
    tick();
    check("abort_nodone", 8'h04, 8'd5, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 8'h0F, 8'd1, 1'b0, 1'b0);
    tick();
    check("abort_restart", 8'h0F, 8'd1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();
    check("abort_restart_done", 8'h87, 8'd0, 1'b0, 1'b1);
    tick();

    // Asynchronous reset mid-RUN for 15 time units.
    drive(1'b1, 2'd0, 8'h01, 8'd10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("rst_pre", 8'h08, 8'd7, 1'b1, 1'b0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("rst_async", 8'h00, 8'd0, 1'b0, 1'b0);
    #14 reset = 1'b1;
    tick();
    check("rst_idle1", 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    check("rst_idle2", 8'h00, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 8'h81, 8'd1, 1'b0, 1'b0);
    tick();
    check("rst_restart", 8'h81, 8'd1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();
    check("rst_restart_done", 8'h03, 8'd0, 1'b0, 1'b1);
    tick();
    check("model_sync", m_pat, m_left, m_running, m_fin);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), W'($urandom),
            W'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      tick();
      check($sformatf("rand%0d", n), m_pat, m_left, m_running, m_fin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
